// File: rtl/flt2int_conv.sv
// flt2int_conv: multi-cycle float to saturating integer converter with four rounding modes
module flt2int_conv #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   flt_in,
  input  logic [1:0]             round_mode,
  output logic                   busy,
  output logic                   done,
  output logic [INT_W-1:0]       int_out,
  output logic                   ovf,
  output logic                   inexact
);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int MW = (INT_W + 1 > MAN_W + 1) ? INT_W + 1 : MAN_W + 1;
  localparam int CAP = MAN_W + 2;
  localparam int CW = $clog2(CAP + 1);
  localparam logic [MW-1:0] MAXP = {{(MW-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
  localparam logic [MW-1:0] SATM = {{(MW-INT_W){1'b0}}, 1'b1, {(INT_W-1){1'b0}}};
  localparam logic [2:0] IDLE = 3'd0, PARSE = 3'd1, SHIFT = 3'd2, ROUND = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic sign, nan, left, guard, sticky, inc, sat, all1, zero, mz, big;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic [1:0] rm;
  logic [MW-1:0] mag, sig, rnd;
  logic [CW-1:0] cnt;
  logic [INT_W-1:0] mo, res;
  int e, n, nc;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    e = {{(32-EXP_W){1'b0}}, exp_f} - BIAS;
    n = e >= MAN_W ? e - MAN_W : MAN_W - e;
    nc = n > CAP ? CAP : n;
    sig = MW'({1'b1, man_f});
    all1 = &exp_f;
    zero = ~|exp_f;
    mz = ~|man_f;
    big = all1 || e > INT_W - 2;
    inc = rm == 2'd0 ? 1'b0 :
          rm == 2'd1 ? guard & (sticky | mag[0]) :
          rm == 2'd2 ? sign & (guard | sticky) : !sign & (guard | sticky);
    rnd = mag + {{(MW-1){1'b0}}, inc};
    sat = rnd > MAXP;
    mo = sat ? MAXP[INT_W-1:0] : rnd[INT_W-1:0];
    res = nan ? '0 : sign ? -mo : mo;
  end
  // Special operands enter ROUND with a prepared magnitude so one saturation path serves all
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      int_out <= '0;
      ovf <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          {sign, exp_f, man_f} <= flt_in;
          rm <= round_mode;
          state <= PARSE;
        end
        PARSE: begin
          nan <= all1 & !mz;
          guard <= 1'b0;
          sticky <= zero & !mz;
          left <= e >= MAN_W;
          mag <= big ? SATM : zero ? '0 : sig;
          cnt <= CW'(nc);
          state <= (big || zero || nc == 0) ? ROUND : SHIFT;
        end
        SHIFT: begin
          mag <= left ? mag << 1 : mag >> 1;
          guard <= left ? 1'b0 : mag[0];
          sticky <= sticky | guard;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          int_out <= res;
          ovf <= sat;
          inexact <= guard | sticky;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flt2int_conv.sv
// tb_flt2int_conv: directed checks of latency, rounding, specials, abort and a 32-bit instance
module tb_flt2int_conv;
  logic clk = 0, reset = 1, start16 = 0, start32 = 0, seen;
  logic [15:0] flt16 = '0;
  logic [31:0] flt32 = '0;
  logic [1:0] rm = '0;
  logic busy16, done16, ovf16, inx16, busy32, done32, ovf32, inx32;
  logic [15:0] out16;
  logic [31:0] out32;
  int total = 0, passed = 0, errs = 0;
  always #5 clk = ~clk;
  flt2int_conv dut16 (.clk(clk), .reset(reset), .start(start16), .flt_in(flt16), .round_mode(rm),
    .busy(busy16), .done(done16), .int_out(out16), .ovf(ovf16), .inexact(inx16));
  flt2int_conv #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut32 (.clk(clk), .reset(reset), .start(start32),
    .flt_in(flt32), .round_mode(rm), .busy(busy32), .done(done32), .int_out(out32), .ovf(ovf32),
    .inexact(inx32));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic w, input logic [31:0] f, input logic [1:0] m, input int n,
                     input logic [31:0] eo, input logic eovf, input logic einx, input int poke,
                     input string tag);
    int lat = 0;
    logic bz = 1;
    rm = m;
    if (w) begin start32 = 1; flt32 = f; end
    else begin start16 = 1; flt16 = f[15:0]; end
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      start16 = 0;
      start32 = 0;
      if (w ? done32 : done16) begin lat = j; break; end
      if (!(w ? busy32 : busy16)) bz = 0;
      if (j == poke) begin start16 = 1; flt16 = 16'h7800; end
    end
    chk({tag, "_lat"}, lat, n + 3);
    chk({tag, "_busy"}, {31'b0, bz}, 1);
    chk({tag, "_busy_at_done"}, {31'b0, w ? busy32 : busy16}, 0);
    chk({tag, "_out"}, w ? out32 : {16'h0, out16}, eo);
    chk({tag, "_ovf"}, {31'b0, w ? ovf32 : ovf16}, {31'b0, eovf});
    if (einx !== 1'bx) chk({tag, "_inx"}, {31'b0, w ? inx32 : inx16}, {31'b0, einx});
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_busy", {31'b0, busy16}, 0);
    chk("rst_done", {31'b0, done16}, 0);
    chk("rst_out", {16'h0, out16}, 0);
    chk("rst_flags", {30'b0, ovf16, inx16}, 0);
    chk("rst_out32", out32, 0);
    reset = 0;
    @(negedge clk);
    run(0, 16'h4204, 2'd0, 9, 32'h0003, 0, 1, 0, "p3_rz");
    run(0, 16'hEC10, 2'd1, 2, 32'hEFC0, 0, 0, 0, "n4160_rne");
    run(0, 16'h4100, 2'd0, 9, 32'h0002, 0, 1, 0, "p2_5_rz");
    run(0, 16'h4100, 2'd1, 9, 32'h0002, 0, 1, 0, "p2_5_rne");
    run(0, 16'h4100, 2'd2, 9, 32'h0002, 0, 1, 0, "p2_5_rdn");
    run(0, 16'h4100, 2'd3, 9, 32'h0003, 0, 1, 0, "p2_5_rup");
    run(0, 16'hC100, 2'd0, 9, 32'hFFFE, 0, 1, 0, "n2_5_rz");
    run(0, 16'hC100, 2'd1, 9, 32'hFFFE, 0, 1, 0, "n2_5_rne");
    run(0, 16'hC100, 2'd2, 9, 32'hFFFD, 0, 1, 0, "n2_5_rdn");
    run(0, 16'hC100, 2'd3, 9, 32'hFFFE, 0, 1, 0, "n2_5_rup");
    run(0, 16'h3A00, 2'd1, 11, 32'h0001, 0, 1, 0, "p0_75_rne");
    run(0, 16'h7800, 2'd0, 0, 32'h7FFF, 1, 1'bx, 0, "big_pos");
    run(0, 16'hF800, 2'd0, 0, 32'h8001, 1, 1'bx, 0, "big_neg");
    run(0, 16'h7C00, 2'd0, 0, 32'h7FFF, 1, 1'bx, 0, "inf");
    run(0, 16'h7E00, 2'd0, 0, 32'h0000, 1, 0, 0, "nan");
    run(0, 16'h0001, 2'd3, 0, 32'h0001, 0, 1, 0, "sub_rup");
    run(0, 16'h8001, 2'd2, 0, 32'hFFFF, 0, 1, 0, "nsub_rdn");
    run(0, 16'h8000, 2'd0, 0, 32'h0000, 0, 0, 0, "neg_zero");
    run(0, 16'h4204, 2'd0, 9, 32'h0003, 0, 1, 4, "ign_start");
    rm = 2'd0;
    start16 = 1;
    flt16 = 16'h4204;
    @(negedge clk);
    start16 = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", {31'b0, busy16}, 0);
    chk("abort_done", {31'b0, done16}, 0);
    chk("abort_out", {16'h0, out16}, 0);
    chk("abort_flags", {30'b0, ovf16, inx16}, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done16) seen = 1;
    end
    chk("abort_nodone", {31'b0, seen}, 0);
    run(0, 16'h4100, 2'd3, 9, 32'h0003, 0, 1, 0, "after_abort");
    run(1, 32'h4F000000, 2'd0, 0, 32'h7FFFFFFF, 1, 1'bx, 0, "w_2p31");
    run(1, 32'hC2F6E979, 2'd1, 17, 32'hFFFFFF85, 0, 1, 0, "w_n123");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
